// File: rtl/write_buffer_pkg.sv
// Shared definitions for the write buffer: drain FSM encoding, entry layout
// and the line-address compare used by the read-overtake check.
package write_buffer_pkg;

  localparam int LINE_OFS = 4;
  localparam int ENTRY_W  = 165;

  // One-hot, matching the encoding style of the other cache FSMs
  typedef enum logic [2:0] {
    WB_IDLE = 3'b001,
    WB_REQ  = 3'b010,
    WB_WAIT = 3'b100
  } wb_state_e;

  typedef struct packed {
    logic         wr_type;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wb_entry_t;

  function automatic logic line_match(input logic [31:LINE_OFS] entry_line,
                                      input logic [31:0]        rd_addr);
    return entry_line == rd_addr[31:LINE_OFS];
  endfunction

endpackage

// File: rtl/wb_fifo_mem.sv
// Write-buffer entry storage with per-entry valid bits; exposes the line tag
// and type of every entry so the parent can compare all of them in parallel.
module wb_fifo_mem
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            i_push,
  input  logic [PTR_W-1:0]                i_wr_ptr,
  input  wb_entry_t                       i_wr_entry,
  input  logic                            i_pop,
  input  logic [PTR_W-1:0]                i_rd_ptr,
  output wb_entry_t                       o_rd_entry,
  output logic [DEPTH-1:0]                o_valid,
  output logic [DEPTH-1:0]                o_type,
  output logic [DEPTH-1:0][31:LINE_OFS]   o_line
);

  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;

  // Payload is deliberately not reset; only the valid bits carry state
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[i_wr_ptr] <= i_wr_entry;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_push && (i_wr_ptr == PTR_W'(i))) begin
          r_valid[i] <= 1'b1;
        end else if (i_pop && (i_rd_ptr == PTR_W'(i))) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_type = '0;
    o_line = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_type[i] = r_mem[i].wr_type;
      o_line[i] = r_mem[i].addr[31:LINE_OFS];
    end
  end

  assign o_valid    = r_valid;
  assign o_rd_entry = r_mem[i_rd_ptr];

endmodule

// File: rtl/write_buffer.sv
// In-order write buffer between the Dcache write port and the AXI bridge:
// queues writes, drains one at a time, and stalls reads that would overtake.
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cache_wr_req,
  input  logic         cache_wr_type,
  input  logic [31:0]  cache_wr_addr,
  input  logic [3:0]   cache_wr_wstrb,
  input  logic [127:0] cache_wr_data,
  output logic         cache_wr_rdy,
  output logic         axi_wr_req,
  output logic         axi_wr_type,
  output logic [31:0]  axi_wr_addr,
  output logic [3:0]   axi_wr_wstrb,
  output logic [127:0] axi_wr_data,
  input  logic         axi_wr_rdy,
  input  logic         axi_wr_done,
  input  logic         rd_chk_req,
  input  logic         rd_chk_type,
  input  logic [31:0]  rd_chk_addr,
  output logic         rd_conflict,
  output logic         wb_empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  wb_state_e        r_state;
  wb_state_e        w_state_nxt;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;

  logic             w_push;
  logic             w_pop;
  wb_entry_t        w_wr_entry;
  wb_entry_t        w_rd_entry;
  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_type;
  logic [DEPTH-1:0][31:LINE_OFS] w_line;
  logic             w_line_hit;
  logic             w_word_hit;

  // Ready depends on registered count only, so a same-cycle pop never frees a slot
  assign cache_wr_rdy = (r_count != FULL_CNT);
  assign w_push       = cache_wr_req && cache_wr_rdy;
  assign w_pop        = (r_state == WB_WAIT) && axi_wr_done;
  assign wb_empty     = (r_count == '0);

  assign w_wr_entry = '{wr_type: cache_wr_type,
                        addr:    cache_wr_addr,
                        wstrb:   cache_wr_wstrb,
                        data:    cache_wr_data};

  wb_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk        (clk),
    .resetn     (resetn),
    .i_push     (w_push),
    .i_wr_ptr   (r_wr_ptr),
    .i_wr_entry (w_wr_entry),
    .i_pop      (w_pop),
    .i_rd_ptr   (r_rd_ptr),
    .o_rd_entry (w_rd_entry),
    .o_valid    (w_valid),
    .o_type     (w_type),
    .o_line     (w_line)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= WB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Head entry stays counted until its B response so conflicts cover in-flight data
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = WB_REQ;
        end
      end
      WB_REQ: begin
        if (axi_wr_rdy) begin
          w_state_nxt = WB_WAIT;
        end
      end
      WB_WAIT: begin
        if (axi_wr_done) begin
          w_state_nxt = (r_count > ONE_CNT) ? WB_REQ : WB_IDLE;
        end
      end
      default: w_state_nxt = WB_IDLE;
    endcase
  end

  assign axi_wr_req   = (r_state == WB_REQ);
  assign axi_wr_type  = w_rd_entry.wr_type;
  assign axi_wr_addr  = w_rd_entry.addr;
  assign axi_wr_wstrb = w_rd_entry.wstrb;
  assign axi_wr_data  = w_rd_entry.data;

  always_comb begin
    w_line_hit = 1'b0;
    w_word_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && line_match(w_line[i], rd_chk_addr)) begin
        if (w_type[i]) begin
          w_line_hit = 1'b1;
        end else begin
          w_word_hit = 1'b1;
        end
      end
    end
  end

  // Uncached reads are strongly ordered behind every pending write (MMIO)
  assign rd_conflict = rd_chk_req &&
                       (rd_chk_type ? (w_line_hit || w_word_hit) : (r_count != '0));

  a_done_only_in_wait : assert property (
    @(posedge clk) disable iff (!resetn) axi_wr_done |-> (r_state == WB_WAIT)
  );

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: a bridge model checks every AXI write
// against the queue of writes pushed from the cache side.
module tb_write_buffer;
  import write_buffer_pkg::*;

  localparam int DEPTH = 2;
  localparam int PTR_W = 1;

  logic         clk = 1'b0;
  logic         resetn;
  logic         cache_wr_req;
  logic         cache_wr_type;
  logic [31:0]  cache_wr_addr;
  logic [3:0]   cache_wr_wstrb;
  logic [127:0] cache_wr_data;
  logic         cache_wr_rdy;
  logic         axi_wr_req;
  logic         axi_wr_type;
  logic [31:0]  axi_wr_addr;
  logic [3:0]   axi_wr_wstrb;
  logic [127:0] axi_wr_data;
  logic         axi_wr_rdy;
  logic         axi_wr_done;
  logic         rd_chk_req;
  logic         rd_chk_type;
  logic [31:0]  rd_chk_addr;
  logic         rd_conflict;
  logic         wb_empty;

  int        n_total = 0;
  int        n_bad   = 0;
  wb_entry_t sb_q[$];
  logic      bridge_en = 1'b0;
  int        done_dly  = 5;
  int        hs_cnt    = 0;

  always #5 clk = ~clk;

  write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cache_wr_req   (cache_wr_req),
    .cache_wr_type  (cache_wr_type),
    .cache_wr_addr  (cache_wr_addr),
    .cache_wr_wstrb (cache_wr_wstrb),
    .cache_wr_data  (cache_wr_data),
    .cache_wr_rdy   (cache_wr_rdy),
    .axi_wr_req     (axi_wr_req),
    .axi_wr_type    (axi_wr_type),
    .axi_wr_addr    (axi_wr_addr),
    .axi_wr_wstrb   (axi_wr_wstrb),
    .axi_wr_data    (axi_wr_data),
    .axi_wr_rdy     (axi_wr_rdy),
    .axi_wr_done    (axi_wr_done),
    .rd_chk_req     (rd_chk_req),
    .rd_chk_type    (rd_chk_type),
    .rd_chk_addr    (rd_chk_addr),
    .rd_conflict    (rd_conflict),
    .wb_empty       (wb_empty)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic t, input logic [31:0] a, input logic [3:0] s,
                      input logic [127:0] d);
    wb_entry_t e;
    int n = 0;
    @(negedge clk);
    while (!cache_wr_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cache_wr_rdy) begin
      chk("push_rdy_timeout", 0, 1);
      return;
    end
    cache_wr_req   = 1'b1;
    cache_wr_type  = t;
    cache_wr_addr  = a;
    cache_wr_wstrb = s;
    cache_wr_data  = d;
    e.wr_type = t;
    e.addr    = a;
    e.wstrb   = s;
    e.data    = d;
    sb_q.push_back(e);
    @(negedge clk);
    cache_wr_req = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!wb_empty && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, wb_empty, 1);
  endtask

  task automatic wait_handshake(input int prev);
    int n = 0;
    while (hs_cnt == prev && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (hs_cnt == prev) chk("handshake_timeout", 0, 1);
  endtask

  // Bridge model: accepts a request, checks it against the scoreboard, then
  // returns the write response done_dly cycles later unless reset intervenes.
  initial begin
    wb_entry_t e;
    logic      aborted;
    axi_wr_rdy  = 1'b0;
    axi_wr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn && bridge_en && axi_wr_req) begin
        if (sb_q.size() == 0) begin
          chk("axi_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("axi_type",  axi_wr_type,  e.wr_type);
          chk("axi_addr",  axi_wr_addr,  e.addr);
          chk("axi_wstrb", axi_wr_wstrb, e.wstrb);
          chk("axi_data",  axi_wr_data,  e.data);
        end
        axi_wr_rdy = 1'b1;
        hs_cnt++;
        @(negedge clk);
        axi_wr_rdy = 1'b0;
        aborted = !resetn;
        for (int k = 1; k < done_dly; k++) begin
          @(negedge clk);
          if (!resetn) aborted = 1'b1;
        end
        if (!aborted && resetn) begin
          axi_wr_done = 1'b1;
          @(negedge clk);
          axi_wr_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int prev;
    int n;
    logic seen;
    resetn         = 1'b0;
    cache_wr_req   = 1'b0;
    cache_wr_type  = 1'b0;
    cache_wr_addr  = '0;
    cache_wr_wstrb = '0;
    cache_wr_data  = '0;
    rd_chk_req     = 1'b1;
    rd_chk_type    = 1'b0;
    rd_chk_addr    = 32'h0;

    // Reset state
    #12;
    chk("rst_axi_req",  axi_wr_req,   0);
    chk("rst_rdy",      cache_wr_rdy, 1);
    chk("rst_empty",    wb_empty,     1);
    chk("rst_conflict", rd_conflict,  0);
    @(negedge clk);
    rd_chk_req = 1'b0;
    resetn     = 1'b1;

    // Single line write: request two cycles after the push, held stable
    push(1'b1, 32'h1FC0_0100, 4'hF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("lat_n1_req", axi_wr_req, 0);
    @(negedge clk);
    chk("lat_n2_req",  axi_wr_req,  1);
    chk("lat_n2_addr", axi_wr_addr, 32'h1FC0_0100);
    repeat (2) @(negedge clk);
    chk("req_hold",      axi_wr_req,  1);
    chk("req_hold_addr", axi_wr_addr, 32'h1FC0_0100);
    bridge_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!axi_wr_done && n < 50);
    chk("done_seen",       axi_wr_done, 1);
    chk("busy_at_done",    wb_empty,    0);
    @(negedge clk);
    #1;
    chk("empty_after_done", wb_empty, 1);

    // Fill to full; a request while full must not be taken
    bridge_en = 1'b0;
    push(1'b1, 32'h0000_0100, 4'hF, 128'hA1);
    push(1'b1, 32'h0000_0200, 4'hF, 128'hA2);
    chk("full_rdy",   cache_wr_rdy, 0);
    chk("full_empty", wb_empty,     0);
    cache_wr_req  = 1'b1;
    cache_wr_type = 1'b1;
    cache_wr_addr = 32'h0000_0DEA;
    repeat (3) @(negedge clk);
    chk("full_rdy_hold", cache_wr_rdy, 0);
    cache_wr_req = 1'b0;
    bridge_en    = 1'b1;
    push(1'b1, 32'h0000_0300, 4'hF, 128'hA3);
    wait_empty("fill_drained");
    chk("fill_sb_empty", sb_q.size(), 0);

    // Line read conflict against a pending line write
    bridge_en = 1'b0;
    push(1'b1, 32'h0000_1230, 4'hF, 128'hB0);
    rd_chk_req  = 1'b1;
    rd_chk_type = 1'b1;
    rd_chk_addr = 32'h0000_123C;
    #1 chk("line_same_line", rd_conflict, 1);
    rd_chk_addr = 32'h0000_1240;
    #1 chk("line_next_line", rd_conflict, 0);
    rd_chk_req = 1'b0;
    rd_chk_addr = 32'h0000_123C;
    #1 chk("line_no_req", rd_conflict, 0);
    rd_chk_req = 1'b0;
    bridge_en  = 1'b1;
    wait_empty("line_drained");
    rd_chk_req = 1'b1;
    #1 chk("line_after_done", rd_conflict, 0);
    rd_chk_req = 1'b0;

    // Uncached ordering behind a word write
    bridge_en = 1'b0;
    push(1'b0, 32'hBFAF_8000, 4'b0011, {96'h5555_6666_7777_8888_9999_AAAA, 32'hCAFE_F00D});
    rd_chk_req  = 1'b1;
    rd_chk_type = 1'b1;
    rd_chk_addr = 32'hBFAF_800C;
    #1 chk("word_line_hit", rd_conflict, 1);
    rd_chk_type = 1'b0;
    rd_chk_addr = 32'hBFAF_F000;
    #1 chk("uc_conflict", rd_conflict, 1);
    bridge_en = 1'b1;
    n = 0;
    while (!wb_empty && n < 100) begin
      chk("uc_hold", rd_conflict, 1);
      @(negedge clk);
      #1;
      n++;
    end
    chk("uc_empty",   wb_empty,    1);
    chk("uc_release", rd_conflict, 0);
    rd_chk_req = 1'b0;

    // Push in the same cycle as the done pulse of the only entry
    done_dly = 5;
    prev = hs_cnt;
    push(1'b1, 32'h0000_4000, 4'hF, 128'hC1);
    wait_handshake(prev);
    repeat (5) @(negedge clk);
    cache_wr_req   = 1'b1;
    cache_wr_type  = 1'b1;
    cache_wr_addr  = 32'h0000_5000;
    cache_wr_wstrb = 4'hF;
    cache_wr_data  = 128'hC2;
    begin
      wb_entry_t e;
      e.wr_type = 1'b1;
      e.addr    = 32'h0000_5000;
      e.wstrb   = 4'hF;
      e.data    = 128'hC2;
      sb_q.push_back(e);
    end
    #1 chk("pp_done_now", axi_wr_done, 1);
    @(negedge clk);
    cache_wr_req = 1'b0;
    #1;
    chk("pp_not_empty", wb_empty,     0);
    chk("pp_rdy",       cache_wr_rdy, 1);
    chk("pp_idle",      axi_wr_req,   0);
    wait_empty("pp_drained");
    chk("pp_sb_empty", sb_q.size(), 0);

    // Asynchronous reset in the middle of a write response wait
    bridge_en = 1'b0;
    push(1'b1, 32'h0000_6000, 4'hF, 128'hD1);
    push(1'b1, 32'h0000_7000, 4'hF, 128'hD2);
    done_dly  = 20;
    prev      = hs_cnt;
    bridge_en = 1'b1;
    wait_handshake(prev);
    repeat (3) @(negedge clk);
    rd_chk_req  = 1'b1;
    rd_chk_type = 1'b0;
    #1 chk("ar_pre_conflict", rd_conflict, 1);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("ar_empty",    wb_empty,     1);
    chk("ar_rdy",      cache_wr_rdy, 1);
    chk("ar_axi_req",  axi_wr_req,   0);
    chk("ar_conflict", rd_conflict,  0);
    sb_q.delete();
    rd_chk_req = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axi_wr_req) seen = 1'b1;
    end
    chk("ar_no_stale", seen, 0);
    done_dly = 5;
    push(1'b0, 32'h0000_8004, 4'b1000, 128'hE1);
    wait_empty("ar_fresh_drained");

    repeat (5) @(negedge clk);
    chk("sb_final", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
